// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of the starvation counter: enough to hold 0..max_wait.
  function automatic int wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_chan.sv
// One arbitrated channel: grant selection, lock/owner, round-robin pointer,
// starvation counter and the payload mux toward the shared port.
module dmem_arb_chan
  import dmem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic [1:0]    req,
  input  logic [DW-1:0] pay0,
  input  logic [DW-1:0] pay1,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] s_pay,
  output logic [1:0]    valid
);

  localparam int            WW       = wait_width(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic          lock_reg, lock_next;
  logic          owner_reg, owner_next;
  logic          last_reg, last_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic          grant;
  logic          accept;

  always_comb begin
    grant = 1'b0;
    if (lock_reg) begin
      grant = owner_reg;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end else if (req == 2'b11) begin
      if (ARB_MODE == ARB_RR) grant = ~last_reg;
      else                    grant = (wait_reg == WAIT_MAX);
    end
  end

  // A withdrawn request from the lock owner drops s_ready even while locked.
  assign s_ready = req[grant];
  assign accept  = s_ready & s_valid;
  assign s_pay   = grant ? pay1 : pay0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_valid
      assign valid[gi] = accept & (grant == 1'(gi));
    end
  endgenerate

  always_comb begin
    lock_next  = 1'b0;
    owner_next = owner_reg;
    last_next  = last_reg;
    if (accept) begin
      last_next = grant;
    end else if (s_ready) begin
      lock_next  = 1'b1;
      owner_next = grant;
    end
  end

  always_comb begin
    wait_next = wait_reg;
    if (ARB_MODE == ARB_FIXED) begin
      if (accept && grant)
        wait_next = '0;
      else if (req[1] && !grant && wait_reg != WAIT_MAX)
        wait_next = wait_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lock_reg  <= 1'b0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      wait_reg  <= '0;
    end else begin
      lock_reg  <= lock_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wait_reg  <= wait_next;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the shared dmem port; read and write channels
// are arbitrated independently and read returns are tagged by owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        m0_wready,
  input  logic        m1_wready,
  output logic        m0_wvalid,
  output logic        m1_wvalid,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  input  logic        m0_rready,
  input  logic        m1_rready,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  input  logic [31:0] m0_raddr,
  input  logic [31:0] m1_raddr,
  output logic        m0_rresp,
  output logic        m1_rresp,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_wready,
  input  logic        s_wvalid,
  output logic [31:0] s_waddr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_rready,
  input  logic        s_rvalid,
  output logic [31:0] s_raddr,
  input  logic        s_rresp,
  input  logic [31:0] s_rdata
);

  logic [1:0] w_valid, r_valid, rresp;
  logic       rd_pend_reg, rd_owner_reg;

  dmem_arb_chan #(.ARB_MODE(ARB_MODE), .MAX_WAIT(MAX_WAIT), .DW(68)) u_wr_chan (
    .clk     (clk),
    .resetb  (resetb),
    .req     ({m1_wready, m0_wready}),
    .pay0    ({m0_waddr, m0_wdata, m0_wstrb}),
    .pay1    ({m1_waddr, m1_wdata, m1_wstrb}),
    .s_valid (s_wvalid),
    .s_ready (s_wready),
    .s_pay   ({s_waddr, s_wdata, s_wstrb}),
    .valid   (w_valid)
  );

  dmem_arb_chan #(.ARB_MODE(ARB_MODE), .MAX_WAIT(MAX_WAIT), .DW(32)) u_rd_chan (
    .clk     (clk),
    .resetb  (resetb),
    .req     ({m1_rready, m0_rready}),
    .pay0    (m0_raddr),
    .pay1    (m1_raddr),
    .s_valid (s_rvalid),
    .s_ready (s_rready),
    .s_pay   (s_raddr),
    .valid   (r_valid)
  );

  assign m0_wvalid = w_valid[0];
  assign m1_wvalid = w_valid[1];
  assign m0_rvalid = r_valid[0];
  assign m1_rvalid = r_valid[1];

  // Each return belongs to the accept of the previous cycle only.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= 1'b0;
    end else begin
      rd_pend_reg  <= |r_valid;
      rd_owner_reg <= r_valid[1];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rresp
      assign rresp[gi] = s_rresp & rd_pend_reg & (rd_owner_reg == 1'(gi));
    end
  endgenerate

  assign m0_rresp = rresp[0];
  assign m1_rresp = rresp[1];
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule
